// File: rtl/imem_readback.sv
// rtl/imem_readback.sv - sequential instruction RAM read-back engine streaming words out
// Optional IMEM_READBACK_CHECKSUM_EN adds a running checksum output over accepted words.
module imem_readback #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] count,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_read,
    output logic          mem_write,
    output logic          mem_oe,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
`ifdef IMEM_READBACK_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    // Last WAIT count value; unused when the RAM answers within the issue cycle.
    localparam logic [3:0]    LAT_LAST = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;
    localparam logic [AW-1:0] ONE      = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [3:0]    wait_q, wait_d;
    logic          capture;
    logic          handshake;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wait_d      = wait_q;
        capture     = 1'b0;
        handshake   = (state_q == S_HOLD) && out_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        addr_d      = base;
                        remaining_d = count;
                        state_d     = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                wait_d = '0;
                if (RD_LATENCY == 0) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == LAT_LAST) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    if (remaining_q != ONE) begin
                        addr_d      = addr_q + ONE;
                        remaining_d = remaining_q - ONE;
                        state_d     = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // mem_data is only looked at on the capture edge so idle-bus X never reaches out_data.
    always_comb begin
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        if (capture) begin
            out_data_d = mem_data;
            out_addr_d = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wait_q      <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wait_q      <= wait_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_read  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign mem_oe    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign mem_write = 1'b1;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_HOLD);
    assign done      = (state_q == S_DONE);

`ifdef IMEM_READBACK_CHECKSUM_EN
    logic [DW-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == S_IDLE) && start) begin
            checksum_d = '0;
        end else if (handshake) begin
            checksum_d = checksum_q + out_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_imem_readback.sv
// tb/tb_imem_readback.sv - directed self-checking bench for imem_readback
module tb_imem_readback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [31:0] count = '0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_oe;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
`ifdef IMEM_READBACK_CHECKSUM_EN
    logic [31:0] checksum;
    logic [31:0] done_ck;
`endif

    logic [31:0] ram [16];

    imem_readback #(.AW(32), .DW(32), .RD_LATENCY(1)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .base      (base),
        .count     (count),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_oe    (mem_oe),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef IMEM_READBACK_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    assign mem_data = (mem_read && mem_oe) ? ram[mem_addr[3:0]] : 32'hxxxx_xxxx;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state
    int          mode = 0;
    int          stall_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          first_valid_cyc = -1;
    int          wr_bad = 0;
    bit          rd_seen = 0;
    bit          busy_seen = 0;
    bit          done_busy = 0;
    bit          done_valid = 0;
    bit          prev_valid = 0;
    bit          prev_ready = 0;
    logic [31:0] prev_data = '0;
    logic [31:0] prev_addr = '0;
    logic [31:0] beat_a[$];
    logic [31:0] beat_d[$];
    int          beat_c[$];

    always @(negedge clk) begin
        if (out_valid && prev_valid && !prev_ready) begin
            check("stall_data", out_data, prev_data);
            check("stall_addr", out_addr, prev_addr);
        end
        if (mode == 1) begin
            if (out_valid) begin
                if (stall_cnt == 2) begin
                    out_ready = 1'b1;
                    stall_cnt = 0;
                end else begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end
            end else begin
                out_ready = 1'b0;
            end
        end else begin
            out_ready = 1'b1;
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready && rst_n) begin
            beat_a.push_back(out_addr);
            beat_d.push_back(out_data);
            beat_c.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc   = cyc;
            done_busy  = busy;
            done_valid = out_valid;
`ifdef IMEM_READBACK_CHECKSUM_EN
            done_ck    = checksum;
`endif
        end
        if (mem_write !== 1'b1) wr_bad++;
        if (mem_read) rd_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_addr  = out_addr;
    end

    task automatic clear_mon();
        beat_a.delete();
        beat_d.delete();
        beat_c.delete();
        done_cnt        = 0;
        first_valid_cyc = -1;
        rd_seen         = 1'b0;
        busy_seen       = 1'b0;
        stall_cnt       = 0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_mem_addr"}, mem_addr, 0);
        check({pfx, "_mem_read"}, mem_read, 0);
        check({pfx, "_mem_write"}, mem_write, 1);
        check({pfx, "_mem_oe"}, mem_oe, 0);
        check({pfx, "_out_data"}, out_data, 0);
        check({pfx, "_out_addr"}, out_addr, 0);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
    endtask

    task automatic do_xfer(input string tag, input logic [31:0] b, input logic [31:0] c,
                           input int m, input bit poke);
        int          start_cyc;
        int          budget;
        bit          poked;
        logic [31:0] ea;
        clear_mon();
        mode = m;
        @(negedge clk);
        base      = b;
        count     = c;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start  = 1'b0;
        budget = 0;
        poked  = 1'b0;
        while (done_cnt == 0 && budget < 200) begin
            if (poke && !poked && out_valid) begin
                start = 1'b1;
                base  = 32'h9;
                count = 32'h1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        #1;
        check({tag, "_done_seen"}, done_cnt != 0, 1);
        @(negedge clk);
        #1;
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_beats"}, beat_a.size(), c);
        for (int i = 0; i < beat_a.size() && i < int'(c); i++) begin
            ea = b + 32'(i);
            check($sformatf("%s_addr%0d", tag, i), beat_a[i], ea);
            check($sformatf("%s_data%0d", tag, i), beat_d[i], 32'h1000 + {28'd0, ea[3:0]});
        end
        check({tag, "_done_busy"}, done_busy, 0);
        check({tag, "_done_valid"}, done_valid, 0);
        if (c == 0) begin
            check({tag, "_no_read"}, rd_seen, 0);
            check({tag, "_no_busy"}, busy_seen, 0);
            check({tag, "_done_lat"}, done_cyc - start_cyc, 1);
        end else begin
            check({tag, "_first_lat"}, first_valid_cyc - start_cyc, 3);
            if (beat_c.size() != 0)
                check({tag, "_done_after_last"}, done_cyc - beat_c[beat_c.size() - 1], 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h1000 + i;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        do_xfer("basic", 32'h0, 32'd4, 0, 1'b0);
        do_xfer("stall", 32'h0, 32'd4, 1, 1'b1);
`ifdef IMEM_READBACK_CHECKSUM_EN
        check("checksum", done_ck, 32'h0000_4006);
`endif
        do_xfer("zero", 32'h3, 32'd0, 0, 1'b0);
        do_xfer("wrap", 32'hFFFF_FFFF, 32'd2, 0, 1'b0);

        clear_mon();
        mode = 0;
        @(negedge clk);
        base  = 32'h0;
        count = 32'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_wait_read", mem_read, 1);
        check("abort_wait_addr", mem_addr, 1);
        check("abort_wait_valid", out_valid, 0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_vals("abort");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        do_xfer("after_abort", 32'h5, 32'd2, 0, 1'b0);

        check("mem_write_high", wr_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
